// File: rtl/ins_pkg.sv
// Shared definitions for the instruction prefetch queue: default widths,
// opcode encoding and the word-to-field split.
package ins_pkg;

  localparam int INS_W_DEF = 8;
  localparam int OPC_W_DEF = 4;

  typedef enum logic [OPC_W_DEF-1:0] {
    OP_NOP = 'h0,
    OP_LD  = 'h1,
    OP_ST  = 'h2,
    OP_ADD = 'h3,
    OP_SUB = 'h4,
    OP_AND = 'h5,
    OP_OR  = 'h6,
    OP_XOR = 'h7,
    OP_JMP = 'h8,
    OP_BRZ = 'h9
  } opc_e;

  typedef struct packed {
    logic [INS_W_DEF-OPC_W_DEF-1:0] imed;
    opc_e                           opc;
  } ins_fields_t;

  // Opcode lives in the low bits, immediate/register field above it.
  function automatic ins_fields_t ins_split(input logic [INS_W_DEF-1:0] w);
    ins_fields_t f;
    f.imed = w[INS_W_DEF-1:OPC_W_DEF];
    f.opc  = opc_e'(w[OPC_W_DEF-1:0]);
    return f;
  endfunction

endpackage

// File: rtl/ins_queue_mem.sv
// Queue storage: DEPTH x INS_W register array, one write port and an
// asynchronous read port. Storage is intentionally not reset.
module ins_queue_mem
  import ins_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int INS_W = INS_W_DEF
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [INS_W-1:0]         i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [INS_W-1:0]         o_rdata
);

  logic [DEPTH-1:0][INS_W-1:0] r_mem;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ins_queue.sv
// Instruction prefetch queue between fetch and decode with branch flush.
// Optional INS_QUEUE_BYPASS_EN adds a zero-latency path when empty.
module ins_queue
  import ins_pkg::*;
#(
  parameter int INS_W = INS_W_DEF,
  parameter int OPC_W = OPC_W_DEF,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [INS_W-1:0]           in_ins,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OPC_W-1:0]           opcode,
  output logic [INS_W-OPC_W-1:0]     imed_reg,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [PTR_W-1:0] r_wptr, r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             w_empty, w_full, w_push, w_pop, w_byp, w_we;
  logic [INS_W-1:0] w_rdata, w_head;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_W'(DEPTH));

`ifdef INS_QUEUE_BYPASS_EN
  assign w_byp = w_empty && in_valid && !flush;
`else
  assign w_byp = 1'b0;
`endif

  assign in_ready  = !w_full;
  assign out_valid = !w_empty || w_byp;
  assign w_pop     = !w_empty && out_ready;
  // A bypassed word taken by the decoder the same cycle never lands in storage.
  assign w_push    = in_valid && !w_full && !(w_byp && out_ready);
  assign w_we      = w_push && rst_n && !flush;

  ins_queue_mem #(.DEPTH(DEPTH), .INS_W(INS_W)) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wptr),
    .i_wdata (in_ins),
    .i_raddr (r_rptr),
    .o_rdata (w_rdata)
  );

  assign w_head   = w_byp ? in_ins : w_rdata;
  assign opcode   = out_valid ? w_head[OPC_W-1:0]     : '0;
  assign imed_reg = out_valid ? w_head[INS_W-1:OPC_W] : '0;
  assign count    = r_count;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: doc/ins_queue.md
Name: ins_queue

Overview:
- Parametrised instruction prefetch queue. It is the next-generation replacement for the single-entry instruction register.
- Sits between instruction memory fetch and the decoder.
- Buffers up to DEPTH fetched instruction words using valid/ready handshakes on both sides.
- Presents the head word split into opcode and immediate/register fields.
- Supports a synchronous flush for branches.

Parameters:
- INS_W, 8: instruction word width in bits.
- OPC_W, 4: opcode width. The opcode occupies bits [OPC_W-1:0]; the immediate/register field occupies bits [INS_W-1:OPC_W].
- DEPTH, 4: number of queue entries. Must be a power of two and at least 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  synchronous reset, active-low
- flush  input  1  discard all queued entries (branch taken)
- in_valid  input  1  fetch side presents a word on in_ins
- in_ready  output  1  queue can accept a word this cycle
- in_ins  input  INS_W  fetched instruction word
- out_valid  output  1  head entry available to the decoder
- out_ready  input  1  decoder consumes the head this cycle
- opcode  output  OPC_W  head word bits [OPC_W-1:0]
- imed_reg  output  INS_W-OPC_W  head word bits [INS_W-1:OPC_W]
- count  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - Read and write pointers and count go to 0, so out_valid=0 and in_ready=1.
  - Storage contents are don't-care. opcode and imed_reg read 0.
  - Reset overrides every other input.
- Push occurs when in_valid && in_ready. in_ready = (count != DEPTH), with no combinational path from out_ready.
- Pop occurs when out_valid && out_ready. out_valid = (count != 0).
- Latency: a word pushed at edge N is visible on opcode/imed_reg with out_valid=1 after edge N, i.e. one cycle, when the queue was empty.
- Ordering: strict FIFO.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Push and pop in the same cycle: both take effect and count is unchanged. When full this cannot occur because in_ready=0.
- Full: in_ready=0. A word presented with in_valid=1 is not stored and must be held by the fetch side.
- Empty: out_valid=0 and out_ready is ignored. opcode and imed_reg are forced to 0.
- Outputs are driven from head storage, masked to 0 when empty. Field split is a pure bit-slice of the head entry.
- Flush (flush=1, rst_n=1):
  - Next state is pointers=0 and count=0.
  - Any push or pop in that cycle is discarded; the pushed word is lost.
  - out_valid=0 from the next cycle.
- Reset applied mid-stream discards all entries identically to flush.
- The count output is registered and matches the internal occupancy.

Optional Feature:
- Macro: INS_QUEUE_BYPASS_EN
- Defined:
  - When count==0 && in_valid && !flush, out_valid=1 in the same cycle and opcode/imed_reg reflect in_ins combinationally.
  - If out_ready=1 that cycle, the word is consumed and not written; count stays 0.
  - Otherwise it is written normally.
  - Zero-latency path on empty.
- Undefined: no combinational in-to-out path, and the one-cycle latency above applies.

Decomposition:
- Shared package ins_pkg:
  - INS_W_DEF=8 and OPC_W_DEF=4 constants.
  - An opcode enumeration typedef sized by OPC_W.
  - A field-slice function returning {imed, opcode} from a word.
- One natural sub-module, ins_queue_mem: a DEPTH x INS_W register array with a single write port and an asynchronous read port, with no reset on storage.
- Pointer, count and handshake logic stay in ins_queue.

Test Plan:
- Reset then idle: hold rst_n=0 for 2 cycles, release → count=0, out_valid=0, in_ready=1, opcode=0, imed_reg=0.
- Single push: in_ins=8'hA5 for one cycle, out_ready=0 → next cycle out_valid=1, opcode=4'h5, imed_reg=4'hA, count=1.
- Fill and full, DEPTH=4: push 8'h10, 8'h21, 8'h32, 8'h43, then offer 8'h54 → in_ready=0, count=4. Popping four times then yields opcodes 0,1,2,3 in order and count=0.
- Wrap and concurrent traffic: keep in_valid=1 and out_ready=1 for 10 cycles with incrementing words → count steady after the first cycle, output sequence equals input sequence across pointer wrap.
- Flush mid-stream: with 3 entries, assert flush together with in_valid=1 (in_ins=8'hFF) → next cycle count=0, out_valid=0. A subsequent push of 8'h12 outputs opcode=2, not the flushed or in-flight data.
- Bypass (INS_QUEUE_BYPASS_EN defined), empty queue: in_ins=8'h7C, in_valid=1, out_ready=1 → same cycle out_valid=1, opcode=4'hC, imed_reg=4'h7; next cycle count=0.
